// File: rtl/mem_mport_pkg.sv
// Shared definitions for the mem_mport multi-read-port RAM.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
// Contents: read-during-write mode constants, clear-FSM state enum and the
// write-strobe to bit-mask expansion used by the write and sync-read paths.
package mem_mport_pkg;

  // Sync-read behaviour when the read address matches a committing write.
  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;

  // Upper bounds for the strobe-mask helper; instances slice the result.
  localparam int MAX_W     = 1024;
  localparam int MAX_STRB  = 128;
  localparam int MAX_W_AW  = $clog2(MAX_W);
  localparam int MAX_S_AW  = $clog2(MAX_STRB);

  typedef enum logic {
    CLR_IDLE = 1'b0,
    CLR_RUN  = 1'b1
  } clr_state_t;

  // Expand one strobe bit per byte_w-bit lane into a per-bit mask. Bits at or
  // above width stay zero, so a partial top lane is clipped naturally.
  function automatic logic [MAX_W-1:0] strb_mask(
    input logic [MAX_STRB-1:0] strb,
    input int                  width,
    input int                  byte_w
  );
    logic [MAX_W-1:0] m;
    m = '0;
    for (int b = 0; b < MAX_W; b++) begin
      if (b < width) begin
        m[MAX_W_AW'(b)] = strb[MAX_S_AW'(b / byte_w)];
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/mem_mport_clr.sv
// Sequential clear engine: walks the array once, zeroing one word per cycle.
// Latency: busy rises the cycle after clr_req; clear lasts exactly DEPTH cycles.
// Backpressure: none; clr_req is ignored while a clear is running.
// Ports: clk/rst_n, clr_req (1-cycle pulse), busy, clr_we + clr_addr toward
// the array write mux.
module mem_mport_clr
  import mem_mport_pkg::*;
#(
  parameter int DEPTH        = 64,
  parameter int AW           = 6,
  parameter int CLR_ON_RESET = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_req,
  output logic          busy,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr
);

  localparam clr_state_t      RST_STATE = (CLR_ON_RESET != 0) ? CLR_RUN : CLR_IDLE;
  localparam logic [AW-1:0]   LAST_ADDR = AW'(DEPTH - 1);

  clr_state_t    state, state_nxt;
  logic [AW-1:0] ptr, ptr_nxt;

  // Reset mid-clear lands back in RST_STATE with ptr=0: a restart when
  // clear-on-reset is enabled, an abort otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RST_STATE;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    busy      = 1'b0;
    clr_we    = 1'b0;
    case (state)
      CLR_IDLE: begin
        if (clr_req) state_nxt = CLR_RUN;
      end
      CLR_RUN: begin
        busy   = 1'b1;
        clr_we = 1'b1;
        if (ptr == LAST_ADDR) begin
          state_nxt = CLR_IDLE;
          ptr_nxt   = '0;
        end else begin
          ptr_nxt = ptr + 1'b1;
        end
      end
      default: state_nxt = CLR_IDLE;
    endcase
  end

  assign clr_addr = ptr;

endmodule

// File: rtl/mem_mport.sv
// Multi-read-port RAM with one byte-masked write port and a clear engine.
// Latency: reads 0 cycles (SYNCREAD=0) or 1 cycle (SYNCREAD=1); writes commit at the edge.
// Backpressure: none; writes and reads are dropped/gated while busy.
// Ports: clk, rst_n, clr_req/busy, per-port ren/raddr/rdata/rvalid (port i at
// slice i), single write port wen/waddr/wdata/wstrb.
module mem_mport
  import mem_mport_pkg::*;
#(
  parameter int  WIDTH        = 80,
  parameter int  DEPTH        = 64,
  parameter int  NRD          = 2,
  parameter int  SYNCREAD     = 0,
  parameter int  RDW_MODE     = 0,
  parameter int  BYTE_W       = 8,
  parameter int  CLR_ON_RESET = 1,
  localparam int AW           = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int NSTRB        = (WIDTH + BYTE_W - 1) / BYTE_W
) (
  (* remu_clock *)
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr_req,
  output logic                 busy,
  input  logic [NRD-1:0]       ren,
  input  logic [NRD*AW-1:0]    raddr,
  output logic [NRD*WIDTH-1:0] rdata,
  output logic [NRD-1:0]       rvalid,
  input  logic                 wen,
  input  logic [AW-1:0]        waddr,
  input  logic [WIDTH-1:0]     wdata,
  input  logic [NSTRB-1:0]     wstrb
);

  localparam logic [AW:0] DEPTH_EXT = (AW+1)'(DEPTH);

  logic             clr_we;
  logic [AW-1:0]    clr_addr;
  logic [WIDTH-1:0] wmask;
  logic             wr_commit;
  logic [WIDTH-1:0] mem [DEPTH];

  mem_mport_clr #(
    .DEPTH        (DEPTH),
    .AW           (AW),
    .CLR_ON_RESET (CLR_ON_RESET)
  ) u_clr (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_req  (clr_req),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  assign wmask     = WIDTH'(strb_mask(MAX_STRB'(wstrb), WIDTH, BYTE_W));
  // Out-of-range addresses (DEPTH not a power of two) must not alias.
  assign wr_commit = wen & ~busy & ({1'b0, waddr} < DEPTH_EXT);

  // Array itself is never reset; the clear engine owns it while busy, so the
  // clear write simply takes priority over the (already gated) user write.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else if (wr_commit) begin
      mem[waddr] <= (mem[waddr] & ~wmask) | (wdata & wmask);
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0]    a;
    logic             in_range;
    logic [WIDTH-1:0] word;

    assign a        = raddr[i*AW +: AW];
    assign in_range = ({1'b0, a} < DEPTH_EXT);
    assign word     = in_range ? mem[a] : '0;

    if (SYNCREAD == 0) begin : g_async
      assign rdata[i*WIDTH +: WIDTH] = busy ? '0 : word;
      assign rvalid[i]               = ren[i] & ~busy;
    end else begin : g_sync
      logic [WIDTH-1:0] cap;
      logic [WIDTH-1:0] rd_q;
      logic             vld_q;

      // New-data mode forwards the strobed lanes of a write committing to
      // the same address this cycle; wr_commit already implies in range.
      always_comb begin
        cap = word;
        if (RDW_MODE == RDW_NEW && wr_commit && waddr == a) begin
          cap = (word & ~wmask) | (wdata & wmask);
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rd_q  <= '0;
          vld_q <= 1'b0;
        end else if (ren[i] && !busy) begin
          rd_q  <= cap;
          vld_q <= 1'b1;
        end else begin
          vld_q <= 1'b0;
        end
      end

      assign rdata[i*WIDTH +: WIDTH] = rd_q;
      assign rvalid[i]               = vld_q;
    end
  end

endmodule
